// File: rtl/usb_boot_status_if.sv
// Bundles the SOF/boot/LED-mode inputs and status outputs of usb_boot_status.
interface usb_boot_status_if #(
    parameter int unsigned NUM_LEDS = 1
);
    logic                    sof_valid;
    logic                    boot_req;
    logic [2*NUM_LEDS-1:0]   led_mode;
    logic [NUM_LEDS-1:0]     led;
    logic                    tick_ms;
    logic                    host_timeout;
    logic                    boot;

    // Driver side: the USB engine / bootloader top.
    modport master (
        output sof_valid, boot_req, led_mode,
        input  led, tick_ms, host_timeout, boot
    );

    // Status block side.
    modport slave (
        input  sof_valid, boot_req, led_mode,
        output led, tick_ms, host_timeout, boot
    );
endinterface

// File: rtl/usb_boot_status.sv
// Bootloader status/timing: ms tick, host-presence timeout, sticky boot,
// and per-LED off/on/breathe/blink drive.
module usb_boot_status #(
    parameter int unsigned CLK_FREQ_HZ = 48000000,
    parameter int unsigned NUM_LEDS    = 1,
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned TIMEOUT_MS  = 1000,
    parameter int unsigned BLINK_MS    = 250
) (
    input  logic               clk,
    input  logic               reset,
    usb_boot_status_if.slave   bus
);
    localparam int unsigned PRESC_DIV = CLK_FREQ_HZ / 1000;
    localparam int unsigned PRESC_MAX = PRESC_DIV - 1;
    localparam int unsigned PRESC_W   = $clog2(PRESC_DIV);
    localparam int unsigned PRES_W    = $clog2(TIMEOUT_MS + 1);
    localparam int unsigned BLINK_W   = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam int unsigned LVL_MAX   = (1 << PWM_BITS) - 1;

    logic [PRESC_W-1:0]  presc_q;
    logic                tick_c;
    logic                tick_q;
    logic [PRES_W-1:0]   pres_q;
    logic                timeout_q;
    logic                boot_q;
    logic [PWM_BITS-1:0] level_q;
    logic                dir_up_q;
    logic [BLINK_W-1:0]  blink_cnt_q;
    logic                blink_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic [NUM_LEDS-1:0] led_c;
    logic [NUM_LEDS-1:0] led_q;

    // Internal tick fires on the prescaler's last count; tick_ms is its registered copy.
    assign tick_c = (presc_q == PRESC_W'(PRESC_MAX));

    // Millisecond prescaler and tick pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= tick_c ? '0 : presc_q + PRESC_W'(1);
            tick_q  <= tick_c;
        end
    end

    // Host-presence counter; SOF wins over a coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pres_q    <= '0;
            timeout_q <= 1'b0;
        end else if (bus.sof_valid) begin
            pres_q    <= '0;
            timeout_q <= 1'b0;
        end else if (tick_c && (pres_q < PRES_W'(TIMEOUT_MS))) begin
            pres_q <= pres_q + PRES_W'(1);
            if (pres_q == PRES_W'(TIMEOUT_MS - 1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Sticky boot command: only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            boot_q <= 1'b0;
        end else begin
            boot_q <= boot_q | timeout_q | bus.boot_req;
        end
    end

    // Triangle breathe level, holding one tick at each end while flipping direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q  <= '0;
            dir_up_q <= 1'b1;
        end else if (tick_c) begin
            if (dir_up_q) begin
                if (level_q == PWM_BITS'(LVL_MAX)) begin
                    dir_up_q <= 1'b0;
                end else begin
                    level_q <= level_q + PWM_BITS'(1);
                end
            end else begin
                if (level_q == '0) begin
                    dir_up_q <= 1'b1;
                end else begin
                    level_q <= level_q - PWM_BITS'(1);
                end
            end
        end
    end

    // Blink toggle every BLINK_MS ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (tick_c) begin
            if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Free-running PWM counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + PWM_BITS'(1);
        end
    end

    // Per-LED mode select; level 0 never lights, MAX lights all but one slot.
    always_comb begin
        led_c = '0;
        for (int i = 0; i < int'(NUM_LEDS); i++) begin
            unique case (bus.led_mode[2*i +: 2])
                2'd0: led_c[i] = 1'b0;
                2'd1: led_c[i] = 1'b1;
                2'd2: led_c[i] = (level_q > pwm_q);
                2'd3: led_c[i] = blink_q;
                default: led_c[i] = 1'b0;
            endcase
        end
    end

    // Registered LED drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_c;
        end
    end

    assign bus.led          = led_q;
    assign bus.tick_ms      = tick_q;
    assign bus.host_timeout = timeout_q;
    assign bus.boot         = boot_q;

endmodule
